// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory_bus port between two requesters.
// One transaction at a time, registered bus side, per-transaction timeout.
module memory_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_bus_enable,
  input  logic                  m0_write_enable,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [31:0]           m0_data_in,
  input  logic [3:0]            m0_write_mask,
  output logic [31:0]           m0_data_read,
  output logic                  m0_data_ready,
  input  logic                  m1_bus_enable,
  input  logic                  m1_write_enable,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [31:0]           m1_data_in,
  input  logic [3:0]            m1_write_mask,
  output logic [31:0]           m1_data_read,
  output logic                  m1_data_ready,
  output logic                  bus_enable,
  output logic                  bus_write_enable,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [31:0]           bus_data_out,
  output logic [3:0]            bus_write_mask,
  input  logic [31:0]           bus_data_read,
  input  logic                  bus_data_ready,
  output logic [1:0]            grant,
  output logic                  timeout_error
);

  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [31:0] ABORT_DATA = 32'hdeadbeef;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_q, last_d;
  logic                    abort_q, abort_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              ready_q, ready_d;
  logic [1:0][31:0]        rdata_q, rdata_d;
  logic                    bus_en_d, bus_we_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_d;
  logic [31:0]             bus_dout_d;
  logic [3:0]              bus_mask_d;
  logic [1:0]              grant_d;
  logic                    terr_d;

  logic [1:0] req_c;
  logic       pick_c, owner_req_c, abort_c, timeout_c, start_c, done_c;

  // Tie goes to whoever did not own the previous transaction.
  assign req_c       = {m1_bus_enable, m0_bus_enable};
  assign pick_c      = (req_c == 2'b11) ? ~last_q : req_c[1];
  assign owner_req_c = req_c[owner_q];
  assign abort_c     = abort_q | ~owner_req_c;
  assign timeout_c   = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);
  assign start_c     = ~bus_data_ready & (req_c != 2'b00);
  assign done_c      = bus_data_ready | timeout_c;

  assign m0_data_ready = ready_q[0];
  assign m1_data_ready = ready_q[1];
  assign m0_data_read  = rdata_q[0];
  assign m1_data_read  = rdata_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      owner_q          <= 1'b0;
      last_q           <= 1'b1;
      abort_q          <= 1'b0;
      cnt_q            <= '0;
      ready_q          <= '0;
      rdata_q          <= '0;
      bus_enable       <= 1'b0;
      bus_write_enable <= 1'b0;
      bus_address      <= '0;
      bus_data_out     <= '0;
      bus_write_mask   <= '0;
      grant            <= '0;
      timeout_error    <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      last_q           <= last_d;
      abort_q          <= abort_d;
      cnt_q            <= cnt_d;
      ready_q          <= ready_d;
      rdata_q          <= rdata_d;
      bus_enable       <= bus_en_d;
      bus_write_enable <= bus_we_d;
      bus_address      <= bus_addr_d;
      bus_data_out     <= bus_dout_d;
      bus_write_mask   <= bus_mask_d;
      grant            <= grant_d;
      timeout_error    <= terr_d;
    end
  end

  // An aborted transaction skips COMPLETE: nobody is waiting for the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_c) state_d = ISSUE;
      ISSUE:    if (done_c) state_d = abort_c ? IDLE : COMPLETE;
      COMPLETE: if (!owner_req_c) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    abort_d    = abort_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    rdata_d    = rdata_q;
    bus_en_d   = bus_enable;
    bus_we_d   = bus_write_enable;
    bus_addr_d = bus_address;
    bus_dout_d = bus_data_out;
    bus_mask_d = bus_write_mask;
    grant_d    = grant;
    terr_d     = timeout_error;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          owner_d    = pick_c;
          abort_d    = 1'b0;
          cnt_d      = '0;
          bus_en_d   = 1'b1;
          grant_d    = pick_c ? 2'b10 : 2'b01;
          bus_we_d   = pick_c ? m1_write_enable : m0_write_enable;
          bus_addr_d = pick_c ? m1_address      : m0_address;
          bus_dout_d = pick_c ? m1_data_in      : m0_data_in;
          bus_mask_d = pick_c ? m1_write_mask   : m0_write_mask;
        end
      end
      ISSUE: begin
        abort_d = abort_c;
        if (32'(cnt_q) != TIMEOUT_CYCLES) cnt_d = cnt_q + CNT_W'(1);
        if (done_c) begin
          bus_en_d = 1'b0;
          bus_we_d = 1'b0;
          if (!bus_data_ready) terr_d = 1'b1;
          if (abort_c) begin
            grant_d = '0;
            last_d  = owner_q;
          end else begin
            ready_d[owner_q] = 1'b1;
            rdata_d[owner_q] = bus_data_ready ? bus_data_read : ABORT_DATA;
          end
        end
      end
      COMPLETE: begin
        if (!owner_req_c) begin
          ready_d[owner_q] = 1'b0;
          grant_d          = '0;
          last_d           = owner_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_memory_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned TO    = 8;
  localparam int          N_RND = 30;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           en, we;
  logic [1:0][AW-1:0]   addr;
  logic [1:0][31:0]     wdata;
  logic [1:0][3:0]      mask;
  logic [31:0]          m0_data_read, m1_data_read;
  logic                 m0_data_ready, m1_data_ready;
  logic                 bus_enable, bus_write_enable;
  logic [AW-1:0]        bus_address;
  logic [31:0]          bus_data_out;
  logic [3:0]           bus_write_mask;
  logic [31:0]          bus_data_read;
  logic                 bus_data_ready;
  logic [1:0]           grant;
  logic                 timeout_error;
  logic [1:0]           rdy;
  logic [1:0][31:0]     rd;

  int n_chk = 0;
  int n_fail = 0;

  assign rdy = {m1_data_ready, m0_data_ready};
  assign rd  = {m1_data_read, m0_data_read};

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_bus_enable(en[0]), .m0_write_enable(we[0]), .m0_address(addr[0]),
    .m0_data_in(wdata[0]), .m0_write_mask(mask[0]),
    .m0_data_read(m0_data_read), .m0_data_ready(m0_data_ready),
    .m1_bus_enable(en[1]), .m1_write_enable(we[1]), .m1_address(addr[1]),
    .m1_data_in(wdata[1]), .m1_write_mask(mask[1]),
    .m1_data_read(m1_data_read), .m1_data_ready(m1_data_ready),
    .bus_enable(bus_enable), .bus_write_enable(bus_write_enable),
    .bus_address(bus_address), .bus_data_out(bus_data_out),
    .bus_write_mask(bus_write_mask), .bus_data_read(bus_data_read),
    .bus_data_ready(bus_data_ready), .grant(grant), .timeout_error(timeout_error)
  );

  typedef struct {
    logic        mst;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          rdy_cyc;   // issue cycle in which the bus answers; 0 = never
    logic [31:0] rdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [AW-1:0] a);
    return {a ^ 16'h5a5a, ~a};
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    en = '0;
    we = '0;
    bus_data_ready = 1'b0;
    bus_data_read = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   k;
    int   exp_k;
    logic o;
    o = v.mst;
    en[o] = 1'b1; we[o] = v.we; addr[o] = v.addr; wdata[o] = v.wdata; mask[o] = v.mask;
    @(negedge clk);
    chk($sformatf("v%0d_bus_en_latency", idx), 32'(bus_enable), 32'd1);
    chk($sformatf("v%0d_grant", idx), 32'(grant), 32'(o ? 2'b10 : 2'b01));
    k = 0;
    while (bus_enable && k < 20) begin
      k++;
      chk($sformatf("v%0d_bus_we", idx), 32'(bus_write_enable), 32'(v.we));
      chk($sformatf("v%0d_bus_addr", idx), 32'(bus_address), 32'(v.addr));
      chk($sformatf("v%0d_bus_dout", idx), bus_data_out, v.wdata);
      chk($sformatf("v%0d_bus_mask", idx), 32'(bus_write_mask), 32'(v.mask));
      bus_data_ready = (k == v.rdy_cyc);
      bus_data_read  = v.rdata;
      @(negedge clk);
    end
    bus_data_ready = 1'b0;
    exp_k = (v.rdy_cyc != 0) ? v.rdy_cyc : int'(TO);
    chk($sformatf("v%0d_issue_cycles", idx), 32'(k), 32'(exp_k));
    chk($sformatf("v%0d_bus_we_drop", idx), 32'(bus_write_enable), 32'd0);
    chk($sformatf("v%0d_ready", idx), 32'(rdy[o]), 32'd1);
    chk($sformatf("v%0d_other_ready", idx), 32'(rdy[~o]), 32'd0);
    if (v.chk_rd) chk($sformatf("v%0d_read", idx), rd[o], v.exp_rd);
    chk($sformatf("v%0d_timeout_err", idx), 32'(timeout_error), 32'(v.exp_to));
    en[o] = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_ready_drop", idx), 32'(rdy[o]), 32'd0);
    chk($sformatf("v%0d_grant_idle", idx), 32'(grant), 32'd0);
  endtask

  task automatic both_seq(input int n);
    logic o;
    int   w;
    en = 2'b11; we = 2'b00; addr[0] = 16'h0a00; addr[1] = 16'h0b00;
    for (int i = 0; i < n; i++) begin
      o = i[0];
      w = 0;
      while (!bus_enable && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("alt%0d_grant", i), 32'(grant), 32'(o ? 2'b10 : 2'b01));
      chk($sformatf("alt%0d_addr", i), 32'(bus_address), 32'(addr[o]));
      bus_data_ready = 1'b1;
      bus_data_read  = 32'h1000 + 32'(i);
      @(negedge clk);
      bus_data_ready = 1'b0;
      chk($sformatf("alt%0d_ready", i), 32'(rdy[o]), 32'd1);
      chk($sformatf("alt%0d_read", i), rd[o], 32'h1000 + 32'(i));
      chk($sformatf("alt%0d_other_ready", i), 32'(rdy[~o]), 32'd0);
      en[o] = 1'b0;
      @(negedge clk);
      chk($sformatf("alt%0d_grant_idle", i), 32'(grant), 32'd0);
      en[o] = 1'b1;
    end
    en = '0;
    @(negedge clk);
  endtask

  // Randomized-run state
  logic       last_m, exp_o, prev_be;
  logic [1:0] act, granted, gwe;
  logic [1:0][AW-1:0] gaddr;
  int issued[2], done_n[2], gap[2];
  int slave_cnt, hold;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h4000, 32'h0,        4'h0,    3, 32'h12345678, 1'b1, 32'h12345678, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h0100, 32'hcafef00d, 4'b1100, 2, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'hffff, 32'h0,        4'h0,    1, 32'ha5a50001, 1'b1, 32'ha5a50001, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 32'h0,        4'h0,    8, 32'h0badf00d, 1'b1, 32'h0badf00d, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h1234, 32'h0,        4'h0,    0, 32'h11111111, 1'b1, 32'hdeadbeef, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'h2222, 32'h0,        4'h0,    2, 32'h600df00d, 1'b1, 32'h600df00d, 1'b1};

    addr = '0; wdata = '0; mask = '0;
    reset_dut();
    chk("rst_bus_en", 32'(bus_enable), 32'd0);
    chk("rst_bus_we", 32'(bus_write_enable), 32'd0);
    chk("rst_bus_addr", 32'(bus_address), 32'd0);
    chk("rst_bus_dout", bus_data_out, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_timeout", 32'(timeout_error), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_m0_read", rd[0], 32'd0);
    chk("rst_m1_read", rd[1], 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a transaction, then a fresh m1 request.
    en[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h3000;
    @(negedge clk);
    chk("midrst_pre_bus_en", 32'(bus_enable), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_bus_en", 32'(bus_enable), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_timeout", 32'(timeout_error), 32'd0);
    chk("midrst_m0_read", rd[0], 32'd0);
    chk("midrst_m1_read", rd[1], 32'd0);
    @(negedge clk);
    reset = 1'b0; en[0] = 1'b0; en[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0042;
    @(negedge clk);
    chk("postrst_bus_en", 32'(bus_enable), 32'd1);
    chk("postrst_grant", 32'(grant), 32'b10);
    chk("postrst_addr", 32'(bus_address), 32'h0042);
    bus_data_ready = 1'b1; bus_data_read = 32'h42424242;
    @(negedge clk);
    bus_data_ready = 1'b0;
    chk("postrst_ready", 32'(rdy[1]), 32'd1);
    chk("postrst_read", rd[1], 32'h42424242);
    en[1] = 1'b0;
    @(negedge clk);

    // Simultaneous requests after reset, then continuous alternation.
    reset_dut();
    both_seq(8);

    // Requester abort: bus finishes, result is discarded.
    en[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0c00;
    @(negedge clk);
    chk("abort_bus_en", 32'(bus_enable), 32'd1);
    en[0] = 1'b0;
    @(negedge clk);
    chk("abort_still_issuing", 32'(bus_enable), 32'd1);
    bus_data_ready = 1'b1; bus_data_read = 32'h77777777;
    @(negedge clk);
    bus_data_ready = 1'b0;
    chk("abort_bus_drop", 32'(bus_enable), 32'd0);
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_ready", 32'(rdy[0]), 32'd0);
    chk("abort_read_held", rd[0], 32'h1006);
    @(negedge clk);
    chk("abort_ready_later", 32'(rdy[0]), 32'd0);

    // Randomized traffic against a transaction-level model.
    reset_dut();
    last_m = 1'b1; prev_be = 1'b0; act = '0; granted = '0; gwe = '0; gaddr = '0;
    slave_cnt = 0; hold = 0;
    for (int m = 0; m < 2; m++) begin
      issued[m] = 0; done_n[m] = 0; gap[m] = 0;
    end
    for (int cyc = 0; cyc < 4000 && (done_n[0] < N_RND || done_n[1] < N_RND); cyc++) begin
      @(negedge clk);
      if (bus_enable && !prev_be) begin
        exp_o = (en == 2'b11) ? ~last_m : en[1];
        chk("rnd_grant", 32'(grant), 32'(exp_o ? 2'b10 : 2'b01));
        chk("rnd_bus_addr", 32'(bus_address), 32'(addr[exp_o]));
        chk("rnd_bus_we", 32'(bus_write_enable), 32'(we[exp_o]));
        chk("rnd_bus_dout", bus_data_out, wdata[exp_o]);
        chk("rnd_bus_mask", 32'(bus_write_mask), 32'(mask[exp_o]));
        last_m = exp_o;
        granted[exp_o] = 1'b1;
        gaddr[exp_o] = addr[exp_o];
        gwe[exp_o] = we[exp_o];
        slave_cnt = $urandom_range(0, 4);
      end
      prev_be = bus_enable;

      if (bus_enable) begin
        if (slave_cnt == 0) begin
          bus_data_ready = 1'b1;
          bus_data_read = memf(bus_address);
          hold = $urandom_range(0, 2);
        end else begin
          slave_cnt--;
          bus_data_ready = 1'b0;
          bus_data_read = $urandom;
        end
      end else if (bus_data_ready && hold > 0) begin
        hold--;
      end else begin
        bus_data_ready = 1'b0;
        bus_data_read = $urandom;
      end

      for (int m = 0; m < 2; m++) begin
        if (rdy[m]) begin
          chk($sformatf("rnd_owner_m%0d", m), 32'(granted[m]), 32'd1);
          if (!gwe[m]) chk($sformatf("rnd_read_m%0d", m), rd[m], memf(gaddr[m]));
        end
        if (act[m]) begin
          if (rdy[m]) begin
            done_n[m]++;
            act[m] = 1'b0; granted[m] = 1'b0; en[m] = 1'b0;
            gap[m] = $urandom_range(0, 2);
          end else if (!granted[m] && $urandom_range(0, 2) == 0) begin
            we[m] = 1'($urandom); addr[m] = AW'($urandom);
            wdata[m] = $urandom; mask[m] = 4'($urandom);
          end
        end else if (gap[m] > 0) begin
          gap[m]--;
        end else if (issued[m] < N_RND) begin
          issued[m]++;
          act[m] = 1'b1; en[m] = 1'b1;
          we[m] = 1'($urandom); addr[m] = AW'($urandom);
          wdata[m] = $urandom; mask[m] = 4'($urandom);
        end
      end
    end
    chk("rnd_done_m0", 32'(done_n[0]), 32'(N_RND));
    chk("rnd_done_m1", 32'(done_n[1]), 32'(N_RND));
    chk("rnd_no_timeout", 32'(timeout_error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
